// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port memory arbiter with fixed/round-robin grant and wait timeout
//
// Purpose: shares one single-outstanding memory interface between a CPU data
// port (port 0) and a loader/debug port (port 1). A request is granted from
// IDLE, the winning command is latched onto mem_*, the access is held in BUSY
// until mem_ready or a wait timeout, and completion is reported to the owner
// through a one-cycle RESP state.
//
// Parameters:
//   ARB_MODE  0 = fixed priority (port 0 wins ties), 1 = round-robin
//   TIMEOUT   BUSY cycles allowed before the access is aborted (2..65535)
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   req*/we*/adr*/wdata*/wsel* per-port request level and command
//   rdata*/done*/err*          per-port read data, completion and timeout pulses
//   mem_req/mem_we/mem_adr/
//   mem_wdata/mem_wsel         memory command of the granted port
//   mem_rdata/mem_ready        memory read data and completion
//   busy/owner                 arbiter activity and index of the granted port

module mem_arbiter #(
  parameter int ARB_MODE = 1,
  parameter int TIMEOUT  = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] adr0,
  input  logic [31:0] adr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic [3:0]  wsel0,
  input  logic [3:0]  wsel1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wsel,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      nextState;
  logic        started;    // low for the first edge after reset release
  logic        lastGrant;
  logic        timedOut;   // the access in flight ended by timeout
  logic [15:0] waitCnt;
  logic        winner;
  logic        grant;
  logic        abort;

  // Tie-break: fixed mode always favours port 0; round-robin favours the port
  // that did not win last time. A lone request always wins.
  always_comb begin
    if (req0 && req1) begin
      winner = (ARB_MODE != 0) ? ~lastGrant : 1'b0;
    end else begin
      winner = req1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    grant     = 1'b0;
    abort     = 1'b0;
    mem_req   = 1'b0;
    busy      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    err0      = 1'b0;
    err1      = 1'b0;
    case (state)
      IDLE: begin
        if (started && (req0 || req1)) begin
          grant     = 1'b1;
          nextState = BUSY;
        end
      end
      BUSY: begin
        mem_req = 1'b1;
        busy    = 1'b1;
        if (mem_ready) begin
          nextState = RESP;
        end else if (waitCnt == WAIT_LAST) begin
          // mem_ready in the same cycle takes precedence over the abort
          abort     = 1'b1;
          nextState = RESP;
        end
      end
      RESP: begin
        busy      = 1'b1;
        done0     = ~owner;
        done1     = owner;
        err0      = ~owner & timedOut;
        err1      = owner & timedOut;
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      started   <= 1'b0;
      lastGrant <= 1'b1;
      owner     <= 1'b0;
      timedOut  <= 1'b0;
      waitCnt   <= 16'd0;
      mem_we    <= 1'b0;
      mem_adr   <= 32'd0;
      mem_wdata <= 32'd0;
      mem_wsel  <= 4'd0;
      rdata0    <= 32'd0;
      rdata1    <= 32'd0;
    end else begin
      started <= 1'b1;
      if (grant) begin
        owner     <= winner;
        lastGrant <= winner;
        timedOut  <= 1'b0;
        waitCnt   <= 16'd0;
        mem_we    <= winner ? we1    : we0;
        mem_adr   <= winner ? adr1   : adr0;
        mem_wdata <= winner ? wdata1 : wdata0;
        mem_wsel  <= winner ? wsel1  : wsel0;
      end
      if (state == BUSY) begin
        if (mem_ready) begin
          if (!mem_we) begin
            if (owner) begin
              rdata1 <= mem_rdata;
            end else begin
              rdata0 <= mem_rdata;
            end
          end
        end else if (abort) begin
          timedOut <= 1'b1;
        end else begin
          waitCnt <= waitCnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req0, req1, we0, we1;
  logic [31:0] adr0, adr1, wdata0, wdata1;
  logic [3:0]  wsel0, wsel1;
  logic [31:0] rdata0, rdata1;
  logic        done0, done1, err0, err1;
  logic        mem_req, mem_we;
  logic [31:0] mem_adr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wsel;
  logic        mem_ready, busy, owner;

  logic        fpReset, fpReq0, fpReq1;
  logic [31:0] fpRdata0, fpRdata1, fpMemAdr, fpMemWdata;
  logic        fpDone0, fpDone1, fpErr0, fpErr1, fpMemReq, fpMemWe, fpBusy, fpOwner;
  logic [3:0]  fpMemWsel;

  mem_arbiter #(.ARB_MODE(1), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .adr0(adr0), .adr1(adr1), .wdata0(wdata0), .wdata1(wdata1),
    .wsel0(wsel0), .wsel1(wsel1),
    .rdata0(rdata0), .rdata1(rdata1),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr),
    .mem_wdata(mem_wdata), .mem_wsel(mem_wsel),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .owner(owner)
  );

  mem_arbiter #(.ARB_MODE(0)) dutFp (
    .clk(clk), .reset(fpReset),
    .req0(fpReq0), .req1(fpReq1), .we0(1'b1), .we1(1'b1),
    .adr0(32'h10), .adr1(32'h20), .wdata0(32'h1), .wdata1(32'h2),
    .wsel0(4'hF), .wsel1(4'hF),
    .rdata0(fpRdata0), .rdata1(fpRdata1),
    .done0(fpDone0), .done1(fpDone1), .err0(fpErr0), .err1(fpErr1),
    .mem_req(fpMemReq), .mem_we(fpMemWe), .mem_adr(fpMemAdr),
    .mem_wdata(fpMemWdata), .mem_wsel(fpMemWsel),
    .mem_rdata(32'hCAFE0000), .mem_ready(1'b1),
    .busy(fpBusy), .owner(fpOwner)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          r0;
    bit          r1;
    logic        w0;
    logic        w1;
    int          delay;
    logic [31:0] rd;
    bit          expOwner;
    bit          expErr;
    int          expCycles;
    logic [31:0] expRd0;
    logic [31:0] expRd1;
  } vec_t;

  vec_t vecs[7];

  // transaction-level reference model state for the random phase
  bit          pend[2];
  logic        pw[2];
  logic [31:0] pa[2];
  logic [31:0] pd[2];
  logic [3:0]  ps[2];
  logic [31:0] rm[2];
  bit          lg;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one complete transaction from IDLE: grant, BUSY with memory delay,
  // RESP, return to IDLE. delay = BUSY cycles without mem_ready before it rises.
  task automatic runTxn(input string name, input bit r0, input bit r1,
                        input logic w0, input logic w1,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [3:0] s0, input logic [3:0] s1,
                        input int delay, input logic [31:0] rd, input bit dropEarly,
                        input bit expOwner, input bit expErr, input int expCycles,
                        input logic [31:0] expRd0, input logic [31:0] expRd1);
    logic [68:0] expCmd;
    int cycles;
    bit finished;
    req0 = r0; req1 = r1; we0 = w0; we1 = w1;
    adr0 = a0; adr1 = a1; wdata0 = d0; wdata1 = d1; wsel0 = s0; wsel1 = s1;
    expCmd = expOwner ? {w1, a1, d1, s1} : {w0, a0, d0, s0};
    @(posedge clk); #1;
    check({name, " grant busy"}, busy, 1'b1);
    check({name, " owner"}, owner, expOwner);
    if (dropEarly) begin
      if (expOwner) req1 = 1'b0; else req0 = 1'b0;
    end
    cycles = 0;
    finished = 0;
    while (!finished && cycles < 12) begin
      check({name, " mem_req"}, mem_req, 1'b1);
      check({name, " mem cmd"}, {mem_we, mem_adr, mem_wdata, mem_wsel}, expCmd);
      mem_ready = (cycles == delay);
      mem_rdata = (cycles == delay) ? rd : $urandom;
      @(posedge clk); #1;
      cycles++;
      mem_ready = 1'b0;
      if (!mem_req) finished = 1;
    end
    check({name, " busy cycles"}, cycles, expCycles);
    check({name, " resp busy"}, busy, 1'b1);
    check({name, " done"}, {done0, done1}, expOwner ? 2'b01 : 2'b10);
    check({name, " err"}, {err0, err1}, expErr ? (expOwner ? 2'b01 : 2'b10) : 2'b00);
    check({name, " rdata"}, {rdata0, rdata1}, {expRd0, expRd1});
    if (expOwner) req1 = 1'b0; else req0 = 1'b0;
    @(posedge clk); #1;
    check({name, " idle"}, {busy, mem_req, done0, done1, err0, err1}, 6'b0);
  endtask

  task automatic doReset();
    req0 = 0; req1 = 0;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int fpGrants;
    int bound;
    bit w;
    int delay;
    logic [31:0] rd;
    bit expErr;
    vecs[0] = '{1, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 1, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1, 1, 1, 1, 1, 32'h11111111, 1, 0, 2, 32'hDEADBEEF, 32'h0};
    vecs[2] = '{1, 1, 1, 1, 0, 32'h22222222, 0, 0, 1, 32'hDEADBEEF, 32'h0};
    vecs[3] = '{0, 1, 0, 0, 5, 32'h33333333, 1, 1, 4, 32'hDEADBEEF, 32'h0};
    vecs[4] = '{0, 1, 0, 0, 3, 32'h44444444, 1, 0, 4, 32'hDEADBEEF, 32'h44444444};
    vecs[5] = '{1, 1, 0, 0, 2, 32'h55555555, 0, 0, 3, 32'h55555555, 32'h44444444};
    vecs[6] = '{1, 1, 0, 0, 0, 32'h66666666, 1, 0, 1, 32'h55555555, 32'h66666666};

    reset = 0; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    adr0 = 0; adr1 = 0; wdata0 = 0; wdata1 = 0; wsel0 = 0; wsel1 = 0;
    mem_rdata = 0; mem_ready = 0;
    fpReset = 0; fpReq0 = 0; fpReq1 = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset cmd", {mem_req, mem_we, mem_adr, mem_wdata, mem_wsel}, 70'b0);
    check("reset outs", {rdata0, rdata1, done0, done1, err0, err1, busy, owner}, 70'b0);

    // first grant only on the second edge after release
    req0 = 1; we0 = 0; adr0 = 32'h100;
    reset = 1;
    @(posedge clk); #1;
    check("release edge1 busy", busy, 1'b0);
    @(posedge clk); #1;
    check("release edge2 busy", {busy, mem_req, owner}, 3'b110);
    // reset mid-BUSY drops mem_req without a clock edge
    #3 reset = 0;
    #1;
    check("async reset mem_req", {mem_req, busy, done0, done1}, 4'b0);
    @(posedge clk); #1;
    check("reset no done", {done0, done1, err0, err1}, 4'b0);
    reset = 1;
    @(posedge clk); #1;
    check("rerelease edge1", busy, 1'b0);
    @(posedge clk); #1;
    check("pending req0 granted", {busy, mem_req, owner}, 3'b110);
    mem_ready = 1; mem_rdata = 32'h12345678;
    @(posedge clk); #1;
    mem_ready = 0;
    check("post-reset done0", {done0, done1, rdata0}, {2'b10, 32'h12345678});
    req0 = 0;
    @(posedge clk); #1;
    check("post-reset idle", busy, 1'b0);

    doReset();
    for (int i = 0; i < 7; i++) begin
      runTxn($sformatf("vec%0d", i), vecs[i].r0, vecs[i].r1, vecs[i].w0, vecs[i].w1,
             32'h100 + 32'(16 * i), 32'h2000 + 32'(16 * i),
             32'hA0000000 + 32'(i), 32'hB0000000 + 32'(i), 4'hF, 4'b0011,
             vecs[i].delay, vecs[i].rd, 1'b0, vecs[i].expOwner, vecs[i].expErr,
             vecs[i].expCycles, vecs[i].expRd0, vecs[i].expRd1);
    end

    doReset();
    lg = 1;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 0; pw[p] = 0; pa[p] = 0; pd[p] = 0; ps[p] = 0; rm[p] = 0;
    end
    for (int it = 0; it < 60; it++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) != 0) begin
          pend[p] = 1; pw[p] = 1'($urandom); pa[p] = $urandom;
          pd[p] = $urandom; ps[p] = 4'($urandom);
        end
      end
      if (!pend[0] && !pend[1]) begin
        w = 1'($urandom);
        pend[w] = 1; pw[w] = 1'($urandom); pa[w] = $urandom;
        pd[w] = $urandom; ps[w] = 4'($urandom);
      end
      w = (pend[0] && pend[1]) ? !lg : pend[1];
      delay = $urandom_range(0, 5);
      rd = $urandom;
      expErr = (delay >= TO);
      if (!expErr && !pw[w]) rm[w] = rd;
      runTxn($sformatf("rand%0d", it), pend[0], pend[1], pw[0], pw[1], pa[0], pa[1],
             pd[0], pd[1], ps[0], ps[1], delay, rd, $urandom_range(0, 3) == 0,
             w, expErr, expErr ? TO : delay + 1, rm[0], rm[1]);
      pend[w] = 0;
      lg = w;
    end

    // fixed priority: port 1 starves while port 0 keeps requesting
    fpReq0 = 1; fpReq1 = 1; fpReset = 1;
    fpGrants = 0;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk); #1;
      if (fpMemReq) begin
        fpGrants++;
        check($sformatf("fp owner k%0d", k), fpOwner, 1'b0);
      end
      if (fpDone1 || fpErr1) check($sformatf("fp done1 k%0d", k), fpDone1, 1'b0);
    end
    check("fp grant count", fpGrants, (45 - 2) / 3 + 1);
    fpReq0 = 0;
    bound = 0;
    while (!(fpMemReq && fpOwner) && bound < 6) begin
      @(posedge clk); #1;
      bound++;
    end
    check("fp port1 after drop", {fpMemReq, fpOwner}, 2'b11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ARB_MODE, default 1, meaning 0 = fixed priority (port 0 always wins), 1 = round-robin.
REQ-002 Parameter TIMEOUT, default 256, meaning maximum BUSY cycles before abort (range 2..65535).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req0/req1  input  1  request level from port 0 (CPU data port) and port 1 (loader/debug port).
REQ-006 we0/we1  input  1  1 = write, 0 = read.
REQ-007 adr0/adr1  input  32  byte address.
REQ-008 wdata0/wdata1  input  32  write data.
REQ-009 wsel0/wsel1  input  4  byte-lane write strobes.
REQ-010 rdata0/rdata1  output  32  read data returned to the port.
REQ-011 done0/done1  output  1  one-cycle completion pulse.
REQ-012 err0/err1  output  1  one-cycle timeout pulse, coincident with done.
REQ-013 mem_req  output  1  memory access request, held until mem_ready or abort.
REQ-014 mem_we, mem_adr[31:0], mem_wdata[31:0], mem_wsel[3:0]  output  latched command of the granted port.
REQ-015 mem_rdata  input  32  memory read data, valid when mem_ready=1.
REQ-016 mem_ready  input  1  memory completion, sampled only while mem_req=1.
REQ-017 busy  output  1  1 in BUSY or RESP; owner  output  1  index of the granted port.

Function
REQ-018 FSM states: IDLE, BUSY, RESP.
REQ-019 IDLE: at a rising edge with req0|req1=1, select the winner, latch its we/adr/wdata/wsel into the mem_* registers, set owner, and enter BUSY; otherwise remain in IDLE.
REQ-020 Arbitration with only one request: that port wins.
REQ-021 Arbitration with both requests, ARB_MODE=0: port 0 wins.
REQ-022 Arbitration with both requests, ARB_MODE=1: the port not in last_grant wins.
REQ-023 last_grant updates to the winner at the IDLE->BUSY edge.
REQ-024 mem_req=1 exactly while in BUSY; the mem_* command is stable throughout BUSY.
REQ-025 BUSY: at an edge with mem_ready=1, do all of the following: enter RESP; if mem_we=0, load mem_rdata into rdata[owner]; leave rdata of the other port unchanged.
REQ-026 A write leaves both rdata outputs unchanged.
REQ-027 RESP lasts exactly one cycle: done[owner]=1, then IDLE.
REQ-028 Minimum latency: req sampled at edge N; mem_req high in cycle N+1; mem_ready at edge N+1 gives done in cycle N+2; the next grant edge is N+3.
REQ-029 Port handshake: a port holds req and its command until it sees done; it drops req, or presents a new command, at the edge ending RESP.
REQ-030 A port that drops req during BUSY still completes its transaction and receives done.
REQ-031 A 16-bit wait counter clears on BUSY entry and increments each BUSY cycle without mem_ready.
REQ-032 When the wait counter reaches TIMEOUT-1 without mem_ready: enter RESP with err[owner]=1 and done[owner]=1, leaving rdata unchanged.
REQ-033 If mem_ready=1 in the same cycle the timeout triggers, mem_ready wins and err stays 0.
REQ-034 Requests arriving in BUSY or RESP wait; they are sampled only in IDLE.
REQ-035 done/err are never asserted for the non-owner port, and never both ports in the same cycle.
REQ-036 busy=1 in BUSY and RESP, 0 in IDLE.

Reset
REQ-037 reset=0 asynchronously forces the following, regardless of current state, including mid-BUSY:
- state=IDLE, mem_req=0, mem_we=0, mem_adr/mem_wdata=0, mem_wsel=0;
- rdata0/rdata1=0, done/err=0, busy=0;
- owner=0, last_grant=1 (so port 0 wins the first tie), wait counter=0.
REQ-038 An aborted transaction produces no done/err; the first grant after release of reset occurs no earlier than the second rising edge.

Verification
REQ-039 Port 0 reads adr=0x100, memory returns 0xDEADBEEF with mem_ready in the first BUSY cycle -> done0 in cycle N+2, rdata0=0xDEADBEEF, rdata1 unchanged.
REQ-040 ARB_MODE=1, req0 and req1 held continuously with writes -> grants alternate 0,1,0,1; done0 and done1 never coincide.
REQ-041 ARB_MODE=0, both requesting continuously -> port 1 never granted while req0=1.
REQ-042 TIMEOUT=4, mem_ready held 0 -> mem_req high 4 cycles, then err1=done1=1 for one cycle, then IDLE.
REQ-043 Port 1 write with wsel1=4'b0011 -> mem_wsel=4'b0011 and mem_wdata stable for all BUSY cycles; rdata1 unchanged.
REQ-044 reset=0 asserted mid-BUSY -> mem_req falls without a clock edge, no done pulse; after release, pending req0 is granted.
